// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for an RV64I single-issue datapath.
// Walks one instruction at a time through FETCH, DECODE, EXEC, MEM and WB.
// It drives every datapath strobe and mux select from that sequence.
// Instruction and data memories may take any number of cycles to answer.
// A bounded wait counter turns a stalled memory into a trap.
// instret counts retired instructions.
module multicycle_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zflag,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             alu_src,
  output logic             mem_to_reg,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  // Wait counter only needs to hold 0 .. MEM_TIMEOUT-1.
  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    C_NONE = 3'd0,
    C_R    = 3'd1,
    C_I    = 3'd2,
    C_LD   = 3'd3,
    C_SD   = 3'd4,
    C_BEQ  = 3'd5
  } class_t;

  state_t            state_reg, state_next;
  class_t            class_reg, class_next;
  class_t            dec_class;
  class_t            sel_class;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              wait_done;
  logic              illegal_reg, illegal_next;
  logic [CNT_W-1:0]  instret_reg, instret_next;
  logic              alu_src_reg, alu_src_next;
  logic              mem_to_reg_reg, mem_to_reg_next;
  logic [1:0]        alu_op_reg, alu_op_next;
  logic              sel_window;
  logic              retire;

  // Raw strobes before the reset gate.
  logic imem_req_c, ir_we_c, pc_we_c, pc_src_c, reg_we_c, mem_rd_c, mem_wr_c;

  assign wait_done = (wait_reg == WAIT_LAST);

  // Opcode classification; anything unlisted is unsupported.
  always_comb begin
    dec_class = C_NONE;
    case (opcode)
      OP_R:    dec_class = C_R;
      OP_I:    dec_class = C_I;
      OP_LD:   dec_class = C_LD;
      OP_SD:   dec_class = C_SD;
      OP_BEQ:  dec_class = C_BEQ;
      default: dec_class = C_NONE;
    endcase
  end

  // Next-state, wait counter, retire and strobe generation.
  always_comb begin
    state_next   = state_reg;
    class_next   = class_reg;
    wait_next    = wait_reg;
    illegal_next = illegal_reg;
    retire       = 1'b0;
    imem_req_c   = 1'b0;
    ir_we_c      = 1'b0;
    pc_we_c      = 1'b0;
    pc_src_c     = 1'b0;
    reg_we_c     = 1'b0;
    mem_rd_c     = 1'b0;
    mem_wr_c     = 1'b0;

    case (state_reg)
      S_FETCH: begin
        imem_req_c = 1'b1;
        ir_we_c    = imem_ready;
        if (imem_ready) begin
          // A ready on the last allowed cycle still counts as success.
          state_next = S_DECODE;
          wait_next  = '0;
        end else if (wait_done) begin
          state_next = S_TRAP;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end

      S_DECODE: begin
        class_next = dec_class;
        if (dec_class == C_NONE) begin
          state_next   = S_TRAP;
          illegal_next = 1'b1;
        end else begin
          state_next = S_EXEC;
        end
      end

      S_EXEC: begin
        case (class_reg)
          C_R, C_I: state_next = S_WB;
          C_LD, C_SD: begin
            state_next = S_MEM;
            wait_next  = '0;
          end
          C_BEQ: begin
            // Branch resolves here; the target is taken only when equal.
            pc_we_c    = 1'b1;
            pc_src_c   = zflag;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
          default: state_next = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_rd_c = (class_reg == C_LD);
        mem_wr_c = (class_reg == C_SD);
        if ((class_reg != C_LD) && (class_reg != C_SD)) begin
          state_next = S_FETCH;
        end else if (dmem_ready) begin
          wait_next = '0;
          if (class_reg == C_LD) begin
            state_next = S_WB;
          end else begin
            // Stores retire as soon as the write is accepted.
            pc_we_c    = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
          end
        end else if (wait_done) begin
          state_next = S_TRAP;
          wait_next  = '0;
        end else begin
          wait_next = wait_reg + WAIT_W'(1);
        end
      end

      S_WB: begin
        reg_we_c   = 1'b1;
        pc_we_c    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end

      S_TRAP: begin
        // Terminal until reset; all strobes stay low.
        state_next = S_TRAP;
      end

      default: begin
        // Encodings 5 and 6 are unreachable; recover cleanly.
        state_next = S_FETCH;
        wait_next  = '0;
      end
    endcase

    // Every new instruction starts with a clean wait count and class.
    if ((state_next == S_FETCH) && (state_reg != S_FETCH)) begin
      wait_next  = '0;
      class_next = C_NONE;
    end
  end

  // instret advances on each retire and wraps naturally.
  always_comb begin
    instret_next = instret_reg;
    if (retire) begin
      instret_next = instret_reg + CNT_W'(1);
    end
  end

  // Registered selects, live only while the instruction is in EXEC, MEM or WB.
  // In DECODE the class register is not loaded yet, so use the decoded class.
  always_comb begin
    alu_src_next    = 1'b0;
    alu_op_next     = 2'b00;
    mem_to_reg_next = 1'b0;
    sel_class       = (state_reg == S_DECODE) ? dec_class : class_reg;
    sel_window      = (state_next == S_EXEC) || (state_next == S_MEM) ||
                      (state_next == S_WB);
    if (sel_window) begin
      case (sel_class)
        C_R: begin
          alu_src_next = 1'b0;
          alu_op_next  = 2'b10;
        end
        C_I, C_SD: begin
          alu_src_next = 1'b1;
          alu_op_next  = 2'b00;
        end
        C_LD: begin
          alu_src_next    = 1'b1;
          alu_op_next     = 2'b00;
          mem_to_reg_next = 1'b1;
        end
        C_BEQ: begin
          alu_src_next = 1'b0;
          alu_op_next  = 2'b01;
        end
        default: begin
          alu_src_next    = 1'b0;
          alu_op_next     = 2'b00;
          mem_to_reg_next = 1'b0;
        end
      endcase
    end
  end

  // State, class, wait counter, trap cause, retire count and selects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_FETCH;
      class_reg      <= C_NONE;
      wait_reg       <= '0;
      illegal_reg    <= 1'b0;
      instret_reg    <= '0;
      alu_src_reg    <= 1'b0;
      alu_op_reg     <= 2'b00;
      mem_to_reg_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      class_reg      <= class_next;
      wait_reg       <= wait_next;
      illegal_reg    <= illegal_next;
      instret_reg    <= instret_next;
      alu_src_reg    <= alu_src_next;
      alu_op_reg     <= alu_op_next;
      mem_to_reg_reg <= mem_to_reg_next;
    end
  end

  // Strobes are forced low while reset is held, independent of the clock.
  assign imem_req   = imem_req_c & rst;
  assign ir_we      = ir_we_c & rst;
  assign pc_we      = pc_we_c & rst;
  assign pc_src     = pc_src_c & rst;
  assign reg_we     = reg_we_c & rst;
  assign mem_rd     = mem_rd_c & rst;
  assign mem_wr     = mem_wr_c & rst;
  assign alu_src    = alu_src_reg;
  assign alu_op     = alu_op_reg;
  assign mem_to_reg = mem_to_reg_reg;
  assign halted     = (state_reg == S_TRAP);
  assign illegal    = illegal_reg;
  assign instret    = instret_reg;
  assign state      = state_reg;

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RV64I single-issue datapath.
- Sequences one instruction at a time through fetch, decode, execute, memory and write-back.
- Generates every datapath strobe: PC write, IR load, regfile write, data-memory read/write and mux selects.
- Handles variable-latency instruction/data memory through ready handshakes, with a timeout trap and a retired-instruction counter.

Parameters:
CNT_W, 32, width of instret counter
MEM_TIMEOUT, 16, max consecutive not-ready cycles tolerated in FETCH or MEM before trapping (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
opcode  input  7  instruction[6:0] from IR, valid from DECODE onward
zflag  input  1  ALU zero flag, sampled in EXEC
imem_ready  input  1  instruction word valid this cycle
dmem_ready  input  1  data access complete this cycle
imem_req  output  1  instruction fetch request
ir_we  output  1  load IR
pc_we  output  1  update PC
pc_src  output  1  0 = PC+4, 1 = branch target
reg_we  output  1  regfile write enable
mem_rd  output  1  data memory read
mem_wr  output  1  data memory write
alu_src  output  1  0 = rs2, 1 = immediate
mem_to_reg  output  1  0 = ALU result, 1 = memory data
alu_op  output  2  ALUop to ALU control
halted  output  1  FSM in TRAP
illegal  output  1  trap cause was an unsupported opcode
instret  output  CNT_W  retired instruction count
state  output  3  debug state encoding

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Encodings 5 and 6 are unreachable and recover to FETCH.
- Reset (rst=0, async): state=FETCH, instret=0, wait counter=0, class=none, halted=0, illegal=0; all strobes 0 immediately. The first transition happens on the first rising edge after rst=1.
- FETCH: imem_req=1; ir_we=imem_ready (combinational).
  - imem_ready=1 -> DECODE.
  - Otherwise the wait counter increments; after MEM_TIMEOUT consecutive not-ready cycles -> TRAP.
  - A ready in the same cycle as the final count wins (goes to DECODE).
- DECODE: one cycle; opcode is registered into class.
  - Legal classes: 0110011 R, 0010011 I, 0000011 LD, 0100011 SD, 1100011 BEQ.
  - Any other opcode -> TRAP with illegal=1.
- Class-driven selects (registered, held stable from EXEC through WB, 0 elsewhere):
  - R: alu_src=0, alu_op=10.
  - I, LD, SD: alu_src=1, alu_op=00.
  - BEQ: alu_src=0, alu_op=01.
  - mem_to_reg=1 only for LD.
- EXEC: one cycle.
  - R/I -> WB.
  - LD/SD -> MEM.
  - BEQ: pc_we=1, pc_src=zflag, instret+1 -> FETCH.
- MEM: mem_rd=1 (LD) or mem_wr=1 (SD), held until dmem_ready.
  - On ready: LD -> WB; SD: pc_we=1, pc_src=0, instret+1 -> FETCH.
  - Timeout rule identical to FETCH.
- WB: reg_we=1, pc_we=1, pc_src=0, instret+1 -> FETCH.
- TRAP: halted=1; all strobes, including imem_req, are 0. Exit only via reset. illegal=0 for timeout traps.
- Wait counter clears on every entry to FETCH or MEM and on any ready.
- pc_we and reg_we assert for exactly one cycle per instruction. pc_we is never asserted in DECODE or TRAP.
- instret wraps modulo 2^CNT_W.
- Latency with ready in the first cycle: R/I = 4 cycles, BEQ = 3, SD = 4, LD = 5. Each not-ready cycle adds one.
- Reset mid-operation (e.g. mem_wr high): strobes drop asynchronously; no partial retire is counted.

Test Plan:
- Reset release, imem_ready=1, opcode=0110011 -> states 0,1,2,4; reg_we and pc_we high only in cycle 4 with pc_src=0; instret=1; alu_op=10 in EXEC/WB.
- opcode=0000011, dmem_ready low 2 cycles -> mem_rd high 3 cycles, then WB with reg_we=1, mem_to_reg=1; total 7 cycles; instret+1.
- opcode=1100011: zflag=1 -> EXEC shows pc_we=1, pc_src=1, back to FETCH after 3 cycles; zflag=0 -> pc_src=0; reg_we never asserted.
- opcode=0110111 -> DECODE goes to TRAP; halted=1, illegal=1; no pc_we/reg_we; stays in TRAP for 20 cycles despite imem_ready=1.
- MEM_TIMEOUT=4, imem_ready=0 for 4 cycles -> TRAP with illegal=0. Repeat with imem_ready=1 on the 4th cycle -> DECODE, no trap.
- SD in MEM with mem_wr=1, rst pulled low mid-cycle -> mem_wr=0 immediately, state=0, instret=0; after release, normal fetch resumes.
